nand_bus_cycle: RTL

NAND_BUS_CYCLE -- requirements
Module: nand_bus_cycle

---
 rtl/nand_bus_cycle.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/nand_bus_cycle.sv
// NAND flash bus cycle engine: timed write/read byte bursts on we_n/re_n and ready/busy waits.
// Every output is registered except io_out, which passes through the upstream wdata while driving.
module nand_bus_cycle #(
  parameter int unsigned T_SU       = 1,
  parameter int unsigned T_WP       = 2,
  parameter int unsigned T_H        = 1,
  parameter int unsigned T_WB       = 4,
  parameter int unsigned RB_TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [9:0] len,
  input  logic [7:0] wdata,
  input  logic [7:0] io_in,
  input  logic       rb,
  output logic       we_n,
  output logic       re_n,
  output logic       io_oe,
  output logic [7:0] io_out,
  output logic [8:0] byte_idx,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       done,
  output logic       timeout
);

  localparam int unsigned PH_MAX01 = (T_SU > T_WP) ? T_SU : T_WP;
  localparam int unsigned PH_MAX   = (PH_MAX01 > T_H) ? PH_MAX01 : T_H;
  localparam int unsigned PH_W     = $clog2(PH_MAX + 1);
  localparam int unsigned LEN_W    = 10;
  localparam int unsigned IDX_W    = 9;
  localparam int unsigned WCNT_W   = 10;

  localparam logic [1:0] OP_WR   = 2'd0;
  localparam logic [1:0] OP_RD   = 2'd1;
  localparam logic [1:0] OP_WAIT = 2'd2;
  localparam logic [1:0] OP_RSVD = 2'd3;

  localparam logic [PH_W-1:0]   SU_LD  = PH_W'(T_SU - 1);
  localparam logic [PH_W-1:0]   WP_LD  = PH_W'(T_WP - 1);
  localparam logic [PH_W-1:0]   H_LD   = PH_W'(T_H - 1);
  localparam logic [WCNT_W-1:0] WB_LIM = WCNT_W'(T_WB);
  localparam logic [WCNT_W-1:0] TO_LIM = WCNT_W'(RB_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_PULSE  = 3'd2,
    S_HOLD   = 3'd3,
    S_WAITRB = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [WCNT_W-1:0] wcnt_inc;
  logic              last_byte;
  logic              tmo_q, tmo_d;
  logic [7:0]        rdd_q, rdd_d;
  logic              rdv_q, rdv_d;
  logic              we_n_q, we_n_d;
  logic              re_n_q, re_n_d;
  logic              oe_q, oe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  assign wcnt_inc  = wcnt_q + WCNT_W'(1);
  assign last_byte = ({1'b0, idx_q} == (len_q - LEN_W'(1)));

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_WR;
      len_q   <= '0;
      idx_q   <= '0;
      ph_q    <= '0;
      wcnt_q  <= '0;
      tmo_q   <= 1'b0;
      rdd_q   <= '0;
      rdv_q   <= 1'b0;
      we_n_q  <= 1'b1;
      re_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      ph_q    <= ph_d;
      wcnt_q  <= wcnt_d;
      tmo_q   <= tmo_d;
      rdd_q   <= rdd_d;
      rdv_q   <= rdv_d;
      we_n_q  <= we_n_d;
      re_n_q  <= re_n_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; strobe outputs are decoded from the next state so they register in step.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    len_d   = len_q;
    idx_d   = idx_q;
    ph_d    = ph_q;
    wcnt_d  = wcnt_q;
    tmo_d   = tmo_q;
    rdd_d   = rdd_q;
    rdv_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op;
          len_d = len;
          idx_d = '0;
          tmo_d = 1'b0;
          if (op == OP_WAIT) begin
            state_d = S_WAITRB;
            wcnt_d  = '0;
          end else if (op == OP_RSVD || len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SETUP;
            ph_d    = SU_LD;
          end
        end
      end
      S_SETUP: begin
        if (ph_q == '0) begin
          state_d = S_PULSE;
          ph_d    = WP_LD;
        end else begin
          ph_d = ph_q - PH_W'(1);
        end
      end
      S_PULSE: begin
        if (ph_q == '0) begin
          state_d = S_HOLD;
          ph_d    = H_LD;
          if (op_q == OP_RD) begin
            rdd_d = io_in;
            rdv_d = 1'b1;
          end
        end else begin
          ph_d = ph_q - PH_W'(1);
        end
      end
      S_HOLD: begin
        if (ph_q == '0) begin
          if (last_byte) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SETUP;
            idx_d   = idx_q + IDX_W'(1);
            ph_d    = SU_LD;
          end
        end else begin
          ph_d = ph_q - PH_W'(1);
        end
      end
      S_WAITRB: begin
        // wcnt_inc counts WAITRB cycles completed at this edge; ready beats the timeout.
        wcnt_d = wcnt_inc;
        if (wcnt_inc >= WB_LIM && rb) begin
          state_d = S_DONE;
        end else if (wcnt_inc >= TO_LIM) begin
          state_d = S_DONE;
          tmo_d   = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    we_n_d = !(state_d == S_PULSE && op_d == OP_WR);
    re_n_d = !(state_d == S_PULSE && op_d == OP_RD);
    oe_d   = (state_d == S_SETUP || state_d == S_PULSE || state_d == S_HOLD) && op_d == OP_WR;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign we_n     = we_n_q;
  assign re_n     = re_n_q;
  assign io_oe    = oe_q;
  assign io_out   = oe_q ? wdata : 8'h00;
  assign byte_idx = idx_q;
  assign rd_data  = rdd_q;
  assign rd_valid = rdv_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign timeout  = tmo_q;

endmodule
